iomem_dma: RTL and testbench
============================

IOMEM_DMA -- requirements
Module: iomem_dma

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning the number of stalled cycles (valid high, ready low) before a transfer aborts with error.
REQ-002 SHALL have port clk, input, 1, the single clock; every flop is on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a transfer.
REQ-005 SHALL have port src_addr, input, 32, the source byte address; bits [1:0] are ignored.
REQ-006 SHALL have port dst_addr, input, 32, the destination byte address; bits [1:0] are ignored.
REQ-007 SHALL have port len, input, 16, the transfer length in 32-bit words.
REQ-008 SHALL have port src_inc, input, 1, which advances the source address by 4 after each word when 1 (for example RAM); the source address is held when 0 (for example the RNG data port).
REQ-009 SHALL have port dst_inc, input, 1, with the same meaning as src_inc for the destination.
REQ-010 SHALL have port abort, input, 1, which requests a stop at the next word boundary.
REQ-011 SHALL have port busy, output, 1, high from the cycle after an accepted start until the cycle done is high.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at the end of a transfer.
REQ-013 SHALL have port error, output, 1, a sticky timeout flag that is cleared by the next accepted start.
REQ-014 SHALL have port xfer_count, output, 16, the number of words fully written in the current or last transfer.
REQ-015 SHALL have port mem_valid, output, 1, the bus request.
REQ-016 SHALL have port mem_ready, input, 1, the responder acknowledge.
REQ-017 SHALL have port mem_wstrb, output, 4, the byte enables; 4'b0000 marks a read.
REQ-018 SHALL have port mem_addr, output, 32, the word-aligned bus address.
REQ-019 SHALL have port mem_wdata, output, 32, the write data.
REQ-020 SHALL have port mem_rdata, input, 32, the read data, valid in the cycle mem_ready is high.

Function
REQ-021 SHALL implement the states IDLE, RD, WR and FIN.
REQ-022 SHALL, in IDLE with start high, latch src_addr and dst_addr with bits [1:0] forced to 0, latch len, src_inc and dst_inc, clear xfer_count and error, and go to RD, or to FIN if len is 0.
REQ-023 SHALL ignore start while busy is high.
REQ-024 SHALL, in RD, drive mem_valid=1, mem_wstrb=0 and mem_addr set to the current source address.
REQ-025 SHALL, on the RD cycle where mem_valid and mem_ready are both high, capture mem_rdata into the data register and go to WR.
REQ-026 SHALL, in WR, drive mem_valid=1, mem_wstrb=4'b1111, mem_addr set to the current destination address and mem_wdata set to the data register.
REQ-027 SHALL, on the WR handshake, increment xfer_count, advance the source and destination addresses per their inc bits with 32-bit wrap-around, and go to FIN if the remaining count reaches 0 or abort was seen; otherwise it SHALL go to RD.
REQ-028 SHALL start the next request in the cycle after a handshake, without inserting an idle bus cycle.
REQ-029 SHALL hold mem_valid, mem_addr, mem_wstrb and mem_wdata stable until the handshake, except on timeout.
REQ-030 SHALL accept an abort pulse at any time while busy, latch it, and act on it only at the WR handshake; an in-flight bus request SHALL never be withdrawn because of abort.
REQ-031 SHALL NOT perform the write for a word whose read has not completed.
REQ-032 SHALL keep a stall counter that increments each cycle with mem_valid high and mem_ready low, and clears on each handshake.
REQ-033 SHALL, when the stall counter reaches TIMEOUT-1 with mem_ready still low, drop mem_valid the next cycle, set error, and go to FIN; xfer_count SHALL NOT be incremented.
REQ-034 SHALL, in FIN, assert done for one cycle, drive busy=0 and mem_valid=0, and return to IDLE.
REQ-035 SHALL accept a start arriving in the FIN cycle; that start SHALL NOT be lost.
REQ-036 SHALL, in IDLE and FIN, drive mem_valid=0, mem_wstrb=0, mem_addr=0 and mem_wdata=0.

Reset
REQ-037 SHALL, with resetn low at a clock edge, go to IDLE and set every output to 0: mem_valid, mem_wstrb, mem_addr, mem_wdata, busy, done, error and xfer_count.
REQ-038 SHALL, on reset during a bus transaction, drop mem_valid on the next edge without waiting for mem_ready; no done pulse SHALL be produced.

Verification
REQ-039 SHALL be verified with: start with src=0x0300_1000, src_inc=0, dst=0x0300_2000, dst_inc=1, len=3, and the responder ready one cycle after valid -> 3 reads of 0x0300_1000, writes to 0x0300_2000, 0x0300_2004 and 0x0300_2008 carrying the read data, done pulses once, xfer_count=3, error=0.
REQ-040 SHALL be verified with: len=0 -> done two cycles after start, no mem_valid, xfer_count=0.
REQ-041 SHALL be verified with: TIMEOUT=8, responder never ready -> mem_valid high for exactly 8 cycles then low, error=1, done pulse, xfer_count=0.
REQ-042 SHALL be verified with: len=5 and abort pulsed during the read of word 2 -> the word-2 write completes, done pulses, xfer_count=2, no third read issued.
REQ-043 SHALL be verified with: dst=0xFFFF_FFFC, dst_inc=1, len=2 -> writes to 0xFFFF_FFFC then 0x0000_0000; start pulsed mid-transfer is ignored.
REQ-044 SHALL be verified with: resetn low during a WR with mem_ready low -> mem_valid=0 on the next edge, all outputs 0, no done pulse.

Source files
------------

// File: rtl/iomem_dma.sv
// Word-granular memory-to-memory copy engine on a valid/ready bus.
// One read then one write per word, back to back, with a stall timeout and a word-boundary abort.
module iomem_dma #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len,
    input  logic        src_inc,
    input  logic        dst_inc,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] xfer_count,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [31:0]   r_src;
    logic [31:0]   r_dst;
    logic [15:0]   r_remain;
    logic          r_src_inc;
    logic          r_dst_inc;
    logic          r_abort;
    logic [SW-1:0] r_stall;
    logic [31:0]   r_data;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [15:0]   r_xfer_count;
    logic          r_mem_valid;
    logic [3:0]    r_mem_wstrb;
    logic [31:0]   r_mem_addr;

    logic [31:0] w_src_next;
    logic [31:0] w_dst_next;
    logic [31:0] w_src_al;
    logic        w_last;
    logic        w_stall_max;

    assign w_src_next  = r_src + (r_src_inc ? 32'd4 : 32'd0);
    assign w_dst_next  = r_dst + (r_dst_inc ? 32'd4 : 32'd0);
    assign w_src_al    = {src_addr[31:2], 2'b00};
    // An abort arriving in the very cycle of the write handshake still counts.
    assign w_last      = (r_remain == 16'd1) || r_abort || abort;
    assign w_stall_max = (r_stall == STALL_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_src        <= 32'd0;
            r_dst        <= 32'd0;
            r_remain     <= 16'd0;
            r_src_inc    <= 1'b0;
            r_dst_inc    <= 1'b0;
            r_abort      <= 1'b0;
            r_stall      <= '0;
            r_data       <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_xfer_count <= 16'd0;
            r_mem_valid  <= 1'b0;
            r_mem_wstrb  <= 4'd0;
            r_mem_addr   <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (r_busy && abort) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (r_state == S_FIN) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    r_state <= S_IDLE;
                    // FIN shares the start path so a back-to-back request is never dropped.
                    if (start) begin
                        r_src        <= w_src_al;
                        r_dst        <= {dst_addr[31:2], 2'b00};
                        r_remain     <= len;
                        r_src_inc    <= src_inc;
                        r_dst_inc    <= dst_inc;
                        r_abort      <= 1'b0;
                        r_stall      <= '0;
                        r_data       <= 32'd0;
                        r_busy       <= 1'b1;
                        r_error      <= 1'b0;
                        r_xfer_count <= 16'd0;
                        if (len == 16'd0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state     <= S_RD;
                            r_mem_valid <= 1'b1;
                            r_mem_wstrb <= 4'd0;
                            r_mem_addr  <= w_src_al;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        r_stall     <= '0;
                        r_data      <= mem_rdata;
                        r_state     <= S_WR;
                        r_mem_wstrb <= 4'hF;
                        r_mem_addr  <= r_dst;
                    end else if (w_stall_max) begin
                        r_stall     <= '0;
                        r_error     <= 1'b1;
                        r_state     <= S_FIN;
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'd0;
                        r_mem_addr  <= 32'd0;
                        r_data      <= 32'd0;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
                end
                S_WR: begin
                    if (mem_ready) begin
                        r_stall      <= '0;
                        r_xfer_count <= r_xfer_count + 16'd1;
                        r_remain     <= r_remain - 16'd1;
                        r_src        <= w_src_next;
                        r_dst        <= w_dst_next;
                        r_data       <= 32'd0;
                        r_mem_wstrb  <= 4'd0;
                        if (w_last) begin
                            r_state     <= S_FIN;
                            r_mem_valid <= 1'b0;
                            r_mem_addr  <= 32'd0;
                        end else begin
                            r_state    <= S_RD;
                            r_mem_addr <= w_src_next;
                        end
                    end else if (w_stall_max) begin
                        r_stall     <= '0;
                        r_error     <= 1'b1;
                        r_state     <= S_FIN;
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'd0;
                        r_mem_addr  <= 32'd0;
                        r_data      <= 32'd0;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign xfer_count = r_xfer_count;
    assign mem_valid  = r_mem_valid;
    assign mem_wstrb  = r_mem_wstrb;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_data;

endmodule

// File: tb/tb_iomem_dma.sv
// Directed bench for iomem_dma: a latency-programmable responder, a bus monitor
// and hand-computed expectations for each scenario.
module tb_iomem_dma;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [31:0] dst_addr = 32'd0;
    logic [15:0] len = 16'd0;
    logic        src_inc = 1'b0;
    logic        dst_inc = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] xfer_count;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    iomem_dma #(.TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .src_inc(src_inc), .dst_inc(dst_inc), .abort(abort),
        .busy(busy), .done(done), .error(error), .xfer_count(xfer_count),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rsp_lat = 1;
    int rsp_cnt = 0;
    int rd_seq = 0;
    int valid_cycles = 0;
    int done_cnt = 0;
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int rb, wb, vb, db, sb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %-16s got %h want %h", tag, got, exp);
        end
    endtask

    // Responder: raise ready after rsp_lat waiting cycles, read data counts up per read.
    initial forever begin
        @(negedge clk);
        if (mem_ready) begin
            mem_ready = 1'b0;
            rsp_cnt = 0;
        end
        if (mem_valid && resetn) begin
            if (rsp_cnt >= rsp_lat) begin
                mem_ready = 1'b1;
                if (mem_wstrb == 4'd0) begin
                    mem_rdata = 32'hDA7A_0000 + 32'(rd_seq);
                    rd_seq++;
                end
            end else begin
                rsp_cnt++;
            end
        end else begin
            rsp_cnt = 0;
        end
    end

    initial forever begin
        @(posedge clk);
        if (resetn && mem_valid) begin
            valid_cycles++;
            if (mem_ready) begin
                if (mem_wstrb == 4'hF) begin
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                end else begin
                    rd_addr_q.push_back(mem_addr);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic snap();
        rb = rd_addr_q.size();
        wb = wr_addr_q.size();
        vb = valid_cycles;
        db = done_cnt;
        sb = rd_seq;
    endtask

    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                      input logic si, input logic di);
        src_addr = s; dst_addr = d; len = n; src_inc = si; dst_inc = di;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 400; i++) begin
            if (done_cnt - db >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 400; i++) begin
            if (wr_addr_q.size() - wb >= n) break;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_count", 32'(xfer_count), 0);
        chk("rst_valid", 32'(mem_valid), 0);
        chk("rst_addr", mem_addr, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Fixed source, incrementing destination, three words.
        snap();
        go(32'h0300_1000, 32'h0300_2000, 16'd3, 1'b0, 1'b1);
        chk("t1_valid0", 32'(mem_valid), 1);
        chk("t1_addr0", mem_addr, 32'h0300_1000);
        chk("t1_wstrb0", 32'(mem_wstrb), 0);
        chk("t1_busy0", 32'(busy), 1);
        wait_done(1);
        chk("t1_done", done_cnt - db, 1);
        chk("t1_nrd", rd_addr_q.size() - rb, 3);
        chk("t1_rd0", rd_addr_q[rb], 32'h0300_1000);
        chk("t1_rd1", rd_addr_q[rb + 1], 32'h0300_1000);
        chk("t1_rd2", rd_addr_q[rb + 2], 32'h0300_1000);
        chk("t1_nwr", wr_addr_q.size() - wb, 3);
        chk("t1_wa0", wr_addr_q[wb], 32'h0300_2000);
        chk("t1_wa1", wr_addr_q[wb + 1], 32'h0300_2004);
        chk("t1_wa2", wr_addr_q[wb + 2], 32'h0300_2008);
        chk("t1_wd0", wr_data_q[wb], 32'hDA7A_0000 + 32'(sb));
        chk("t1_wd2", wr_data_q[wb + 2], 32'hDA7A_0002 + 32'(sb));
        chk("t1_count", 32'(xfer_count), 3);
        chk("t1_error", 32'(error), 0);
        chk("t1_gapless", valid_cycles - vb, 12);
        chk("t1_busy_end", 32'(busy), 0);

        // Zero length: FIN right away, done visible two cycles after start.
        snap();
        go(32'h0000_0100, 32'h0000_0200, 16'd0, 1'b1, 1'b1);
        chk("t2_busy1", 32'(busy), 1);
        chk("t2_done1", 32'(done), 0);
        @(negedge clk);
        chk("t2_done2", 32'(done), 1);
        chk("t2_busy2", 32'(busy), 0);
        @(negedge clk);
        chk("t2_done3", 32'(done), 0);
        chk("t2_novalid", valid_cycles - vb, 0);
        chk("t2_count", 32'(xfer_count), 0);

        // A start landing in the FIN cycle must launch the next transfer.
        snap();
        go(32'h0000_0100, 32'h0000_0200, 16'd0, 1'b1, 1'b1);
        go(32'h0000_0040, 32'h0000_0080, 16'd1, 1'b1, 1'b1);
        wait_done(2);
        chk("t3_dones", done_cnt - db, 2);
        chk("t3_nwr", wr_addr_q.size() - wb, 1);
        chk("t3_wa0", wr_addr_q[wb], 32'h0000_0080);
        chk("t3_count", 32'(xfer_count), 1);

        // Responder never ready: 8 valid cycles, then error.
        rsp_lat = 1000;
        snap();
        go(32'h0000_0100, 32'h0000_0200, 16'd4, 1'b1, 1'b1);
        wait_done(1);
        chk("t4_done", done_cnt - db, 1);
        chk("t4_vcycles", valid_cycles - vb, 8);
        chk("t4_error", 32'(error), 1);
        chk("t4_count", 32'(xfer_count), 0);
        chk("t4_nwr", wr_addr_q.size() - wb, 0);
        chk("t4_valid", 32'(mem_valid), 0);
        rsp_lat = 1;

        // Abort during the second read: second write still completes.
        snap();
        go(32'h0000_1000, 32'h0000_2000, 16'd5, 1'b1, 1'b1);
        chk("t5_err_clr", 32'(error), 0);
        wait_writes(1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(1);
        chk("t5_done", done_cnt - db, 1);
        chk("t5_nrd", rd_addr_q.size() - rb, 2);
        chk("t5_nwr", wr_addr_q.size() - wb, 2);
        chk("t5_wa1", wr_addr_q[wb + 1], 32'h0000_2004);
        chk("t5_wd1", wr_data_q[wb + 1], 32'hDA7A_0001 + 32'(sb));
        chk("t5_count", 32'(xfer_count), 2);

        // Destination wraps past the top of the address space; a mid-transfer start is ignored.
        snap();
        go(32'h0000_0101, 32'hFFFF_FFFE, 16'd2, 1'b1, 1'b1);
        @(negedge clk);
        go(32'h0000_5000, 32'h0000_6000, 16'd7, 1'b1, 1'b1);
        wait_done(1);
        repeat (6) @(negedge clk);
        chk("t6_done", done_cnt - db, 1);
        chk("t6_nrd", rd_addr_q.size() - rb, 2);
        chk("t6_rd1", rd_addr_q[rb + 1], 32'h0000_0104);
        chk("t6_nwr", wr_addr_q.size() - wb, 2);
        chk("t6_wa0", wr_addr_q[wb], 32'hFFFF_FFFC);
        chk("t6_wa1", wr_addr_q[wb + 1], 32'h0000_0000);
        chk("t6_count", 32'(xfer_count), 2);
        chk("t6_vcycles", valid_cycles - vb, 8);

        // Reset while a write is stalled.
        rsp_lat = 3;
        snap();
        go(32'h0000_0010, 32'h0000_0020, 16'd2, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (mem_valid && mem_wstrb == 4'hF) break;
            @(negedge clk);
        end
        chk("t7_in_wr", 32'(mem_wstrb), 32'hF);
        resetn = 1'b0;
        @(negedge clk);
        chk("t7_valid", 32'(mem_valid), 0);
        chk("t7_wstrb", 32'(mem_wstrb), 0);
        chk("t7_addr", mem_addr, 0);
        chk("t7_wdata", mem_wdata, 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_done", 32'(done), 0);
        chk("t7_error", 32'(error), 0);
        chk("t7_count", 32'(xfer_count), 0);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("t7_nodone", done_cnt - db, 0);
        chk("t7_nwr", wr_addr_q.size() - wb, 0);
        chk("t7_idle", 32'(mem_valid), 0);

        // Recovery after reset.
        rsp_lat = 1;
        snap();
        go(32'h0000_0000, 32'h0000_0400, 16'd1, 1'b1, 1'b1);
        wait_done(1);
        chk("t8_done", done_cnt - db, 1);
        chk("t8_count", 32'(xfer_count), 1);
        chk("t8_nwr", wr_addr_q.size() - wb, 1);
        chk("t8_wa0", wr_addr_q[wb], 32'h0000_0400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
